// File: rtl/gps_round_scheduler.sv
// -----------------------------------------------------------------------------
// gps_round_scheduler
//
// Round sequencer and round-robin arbiter in front of the shared GPS
// code-generator core. One round is in flight at a time. For each granted
// request, the block does the following:
//   - loads the satellite number into the core and pulses the round start;
//   - waits for a rising edge of the core's L-code-valid, or for a timeout;
//   - holds the captured codes in a response register until the consumer
//     accepts them.
// Rounds launch only while the LLKI key load is complete.
//
// Ports
//   sys_clk_50         clock, rising edge
//   sync_rst_in        asynchronous active-high reset
//   req_valid/sv_num   per-requester round request and satellite number
//   req_ready          one-hot, one-cycle grant pulse (combinational in IDLE)
//   key_complete       LLKI key-load-complete, sampled only in IDLE
//   core_*             sv_num/start to the core; codes and valid from the core
//   rsp_*              response record with valid/ready handshake
//   busy               high whenever a round is in progress
// -----------------------------------------------------------------------------
module gps_round_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                 sys_clk_50,
  input  logic                 sync_rst_in,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [6*NUM_REQ-1:0] req_sv_num,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 key_complete,
  output logic [5:0]           core_sv_num,
  output logic                 core_start,
  input  logic [12:0]          core_ca_code,
  input  logic [127:0]         core_p_code,
  input  logic [127:0]         core_l_code,
  input  logic                 core_l_code_valid,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [5:0]           rsp_sv_num,
  output logic [12:0]          rsp_ca_code,
  output logic [127:0]         rsp_p_code,
  output logic [127:0]         rsp_l_code,
  output logic                 rsp_timeout,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [ID_W-1:0] rr_ptr;
  logic            lcv_q;
  logic [15:0]     timer;

  logic [5:0]      sv_arr [NUM_REQ];
  logic [ID_W-1:0] idx;
  logic [ID_W-1:0] winner;
  logic [5:0]      winner_sv;
  logic            found;
  logic            grant;
  logic            lcv_rise;
  logic            timer_done;

  // Unpack the flat satellite-number bus into one entry per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sv
    assign sv_arr[g] = req_sv_num[6*g +: 6];
  end

  assign winner_sv  = sv_arr[winner];
  assign lcv_rise   = core_l_code_valid & ~lcv_q;
  assign timer_done = (timer == 16'(TIMEOUT_CYCLES - 1));

  // Round-robin search: find the first set request at or above rr_ptr,
  // wrapping at NUM_REQ. The wrap is written explicitly so that a
  // non-power-of-two NUM_REQ never indexes a requester that does not exist.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    idx    = rr_ptr;
    winner = rr_ptr;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
    end
  end

  // Next-state and control outputs. The grant is also masked by reset: the
  // state reads IDLE as soon as reset asserts, and a grant in that window
  // would acknowledge a request that is never served.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    grant      = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (key_complete && found && !sync_rst_in) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          state_next        = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (lcv_rise || timer_done) state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_50 or posedge sync_rst_in) begin
    if (sync_rst_in) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, whatever the block order.
      state <= state_next;
    end
  end

  // Datapath registers. The timer and the response fields only change in the
  // state that owns them. A rise that coincides with the last timer cycle is
  // checked first, so the captured codes win over the timeout.
  always_ff @(posedge sys_clk_50 or posedge sync_rst_in) begin
    if (sync_rst_in) begin
      // NOTE: the wide capture registers are reset too. They drive outputs
      // that must read zero out of reset and after an aborted round.
      rr_ptr      <= '0;
      lcv_q       <= 1'b0;
      timer       <= '0;
      core_sv_num <= '0;
      rsp_id      <= '0;
      rsp_sv_num  <= '0;
      rsp_ca_code <= '0;
      rsp_p_code  <= '0;
      rsp_l_code  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      lcv_q <= core_l_code_valid;
      case (state)
        S_IDLE: begin
          if (grant) begin
            rsp_id      <= winner;
            core_sv_num <= winner_sv;
            rsp_sv_num  <= winner_sv;
          end
        end
        S_START: timer <= '0;
        S_WAIT: begin
          if (lcv_rise) begin
            rsp_ca_code <= core_ca_code;
            rsp_p_code  <= core_p_code;
            rsp_l_code  <= core_l_code;
            rsp_timeout <= 1'b0;
          end else if (timer_done) begin
            rsp_ca_code <= '0;
            rsp_p_code  <= '0;
            rsp_l_code  <= '0;
            rsp_timeout <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rr_ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gps_round_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gps_round_scheduler
//
// Self-checking bench for gps_round_scheduler (NUM_REQ=4, TIMEOUT_CYCLES=16).
// A behavioural core model answers each core_start with a one-cycle
// l_code_valid pulse after a chosen delay (or never). It drives fresh random
// codes every cycle and records the codes present at the pulse. Expected
// grants come from a round-robin pointer model. Expected responses come from
// the pulse record, or from the timeout rule.
// -----------------------------------------------------------------------------
module tb_gps_round_scheduler;

  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic           clk = 1'b0;
  logic           sync_rst_in;
  logic [3:0]     req_valid;
  logic [23:0]    req_sv_num;
  logic [3:0]     req_ready;
  logic           key_complete;
  logic [5:0]     core_sv_num;
  logic           core_start;
  logic [12:0]    core_ca_code;
  logic [127:0]   core_p_code;
  logic [127:0]   core_l_code;
  logic           core_l_code_valid;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [5:0]     rsp_sv_num;
  logic [12:0]    rsp_ca_code;
  logic [127:0]   rsp_p_code;
  logic [127:0]   rsp_l_code;
  logic           rsp_timeout;
  logic           busy;

  gps_round_scheduler #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clk_50        (clk),
    .sync_rst_in       (sync_rst_in),
    .req_valid         (req_valid),
    .req_sv_num        (req_sv_num),
    .req_ready         (req_ready),
    .key_complete      (key_complete),
    .core_sv_num       (core_sv_num),
    .core_start        (core_start),
    .core_ca_code      (core_ca_code),
    .core_p_code       (core_p_code),
    .core_l_code       (core_l_code),
    .core_l_code_valid (core_l_code_valid),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_id            (rsp_id),
    .rsp_sv_num        (rsp_sv_num),
    .rsp_ca_code       (rsp_ca_code),
    .rsp_p_code        (rsp_p_code),
    .rsp_l_code        (rsp_l_code),
    .rsp_timeout       (rsp_timeout),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_rr   = 0;

  // Core model controls and the record of the codes shown at the last pulse.
  int           rise_delay = -1;
  int           cnt        = -1;
  bit           fix_en     = 1'b0;
  logic [12:0]  fix_ca;
  logic [127:0] fix_p, fix_l;
  logic [12:0]  pulse_ca;
  logic [127:0] pulse_p, pulse_l;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int pick(input logic [3:0] rv, input int rr);
    for (int k = 0; k < NREQ; k++)
      if (rv[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return 0;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {req_ready, core_sv_num, core_start, rsp_valid, rsp_id,
                          rsp_sv_num, rsp_timeout, busy, rsp_ca_code}, '0);
    check({tag, "_p"}, rsp_p_code, '0);
    check({tag, "_l"}, rsp_l_code, '0);
  endtask

  // Core model: the pulse comes d cycles after the cycle in which core_start
  // is seen. d=0 lands in START, d=1..TMO in WAIT, and d>TMO after the timeout.
  initial begin
    core_l_code_valid = 1'b0;
    core_ca_code = '0;
    core_p_code  = '0;
    core_l_code  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (core_start) cnt = 0;
      else if (cnt >= 0 && cnt < 1000) cnt++;
      if (rise_delay >= 0 && cnt == rise_delay) begin
        if (fix_en) begin
          core_ca_code = fix_ca;
          core_p_code  = fix_p;
          core_l_code  = fix_l;
        end else begin
          core_ca_code = 13'($urandom);
          core_p_code  = {$urandom, $urandom, $urandom, $urandom};
          core_l_code  = {$urandom, $urandom, $urandom, $urandom};
        end
        core_l_code_valid = 1'b1;
        pulse_ca = core_ca_code;
        pulse_p  = core_p_code;
        pulse_l  = core_l_code;
      end else begin
        core_ca_code = 13'($urandom);
        core_p_code  = {$urandom, $urandom, $urandom, $urandom};
        core_l_code  = {$urandom, $urandom, $urandom, $urandom};
        core_l_code_valid = 1'b0;
      end
    end
  end

  // One full round. Called at least 2 time units after a clock edge, with the
  // DUT in IDLE. rsp_ready is held for 'hold' cycles of RESP before acceptance.
  task automatic do_round(input logic [3:0] rv, input logic [23:0] svs, input int exp_w,
                          input int d, input int hold, input logic kc_after);
    logic [3:0]   exp_gnt, exp_next;
    logic [5:0]   exp_sv;
    logic         rise;
    int           lat, exp_lat, starts, changes, grants;
    logic [1:0]   s_id;
    logic [5:0]   s_sv;
    logic [12:0]  s_ca;
    logic [127:0] s_p, s_l;
    logic         s_to;
    exp_gnt = 4'(1 << exp_w);
    exp_sv  = svs[6*exp_w +: 6];
    rise    = (d >= 1) && (d <= TMO);
    // Grant cycle + START cycle, then the WAIT cycles up to the rise or to
    // the end of the timer.
    exp_lat = rise ? d + 2 : TMO + 2;
    key_complete = 1'b1;
    rsp_ready    = (hold == 0);
    rise_delay   = d;
    req_sv_num   = svs;
    req_valid    = rv;
    #1;
    check("grant", req_ready, exp_gnt);
    step();
    check("ready_one_cycle", req_ready, '0);
    req_valid    = '0;
    key_complete = kc_after;
    check("start", core_start, 1'b1);
    check("core_sv", core_sv_num, exp_sv);
    check("id_at_start", rsp_id, exp_w[1:0]);
    lat = 1;
    starts = 0;
    while (!rsp_valid && lat < 60) begin
      step();
      lat++;
      if (core_start) starts++;
    end
    check("latency", lat, exp_lat);
    check("extra_start", starts, 0);
    check("rsp_id", rsp_id, exp_w[1:0]);
    check("rsp_sv", rsp_sv_num, exp_sv);
    check("rsp_timeout", rsp_timeout, !rise);
    check("rsp_ca", rsp_ca_code, rise ? pulse_ca : 13'd0);
    check("rsp_p", rsp_p_code, rise ? pulse_p : 128'd0);
    check("rsp_l", rsp_l_code, rise ? pulse_l : 128'd0);
    s_id = rsp_id; s_sv = rsp_sv_num; s_ca = rsp_ca_code;
    s_p = rsp_p_code; s_l = rsp_l_code; s_to = rsp_timeout;
    changes = 0;
    grants  = 0;
    for (int i = 0; i < hold; i++) begin
      req_valid = 4'hF;
      step();
      if (!rsp_valid || {s_id, s_sv, s_ca, s_p, s_l, s_to} !==
          {rsp_id, rsp_sv_num, rsp_ca_code, rsp_p_code, rsp_l_code, rsp_timeout})
        changes++;
      if (req_ready !== 4'b0) grants++;
    end
    if (hold > 0) begin
      check("hold_stable", changes, 0);
      check("hold_no_grant", grants, 0);
      rsp_ready = 1'b1;
      #1;
    end
    step();
    check("idle_after_accept", {busy, rsp_valid}, 2'b00);
    exp_rr = (exp_w + 1) % NREQ;
    if (hold > 0) begin
      exp_next = key_complete ? 4'(1 << pick(4'hF, exp_rr)) : 4'b0;
      check("regrant_after_release", req_ready, exp_next);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [3:0]  rv;
    logic [23:0] svs;
    int          exp_w;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int viol;
    int d;
    logic [3:0] rv;
    logic [23:0] svs;

    tbl[0]  = '{4'b1101, 24'h3C_81_05, 0};
    tbl[1]  = '{4'b1101, 24'h12_AB_07, 2};
    tbl[2]  = '{4'b1101, 24'hFE_DC_BA, 3};
    tbl[3]  = '{4'b1101, 24'h01_23_45, 0};
    tbl[4]  = '{4'b1101, 24'h55_AA_55, 2};
    tbl[5]  = '{4'b1101, 24'h9F_3E_21, 3};
    tbl[6]  = '{4'b0001, 24'h00_00_3F, 0};
    tbl[7]  = '{4'b0110, 24'h76_54_32, 1};
    tbl[8]  = '{4'b1001, 24'hC0_FF_EE, 3};
    tbl[9]  = '{4'b1000, 24'hBE_EF_01, 3};
    tbl[10] = '{4'b0100, 24'h0F_0F_0F, 2};
    tbl[11] = '{4'b0111, 24'hA5_5A_3C, 0};

    // Reset: all outputs zero, with a grantable request pending throughout.
    sync_rst_in  = 1'b1;
    key_complete = 1'b1;
    req_valid    = 4'hF;
    req_sv_num   = 24'hFFFFFF;
    rsp_ready    = 1'b0;
    #12;
    check_zero("reset");
    req_valid = '0;
    step();
    sync_rst_in = 1'b0;
    step();
    check_zero("after_reset");
    exp_rr = 0;

    // Round-robin table, with rsp_ready held high.
    for (int i = 0; i < 12; i++)
      do_round(tbl[i].rv, tbl[i].svs, tbl[i].exp_w, 2 + i, 0, 1'b1);

    // Single request with fixed codes; the pulse comes 10 cycles after core_start.
    fix_en = 1'b1;
    fix_ca = 13'h1ABC;
    fix_p  = 128'h1;
    fix_l  = 128'h2;
    do_round(4'b0001, 24'h00_00_05, 0, 10, 0, 1'b1);
    fix_en = 1'b0;
    check("single_ca", rsp_ca_code, 13'h1ABC);
    check("single_p", rsp_p_code, 128'h1);
    check("single_l", rsp_l_code, 128'h2);

    // Key gating: nothing is granted for 50 cycles, then a grant comes in the
    // same cycle that the key rises.
    key_complete = 1'b0;
    req_valid    = 4'b0010;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (req_ready !== 4'b0 || busy !== 1'b0) viol++;
    end
    check("key_gate", viol, 0);
    do_round(4'b0010, 24'h00_0A_00, 1, 4, 0, 1'b1);

    // Timeout corners: no pulse, pulse in START, pulse on the last timer
    // cycle, and pulse one cycle too late.
    do_round(4'b1000, 24'h2A_00_00, pick(4'b1000, exp_rr), -1, 0, 1'b1);
    do_round(4'b0100, 24'h00_15_00, pick(4'b0100, exp_rr), 0, 0, 1'b1);
    do_round(4'b0001, 24'h00_00_2B, pick(4'b0001, exp_rr), TMO, 0, 1'b1);
    do_round(4'b0010, 24'h00_07_00, pick(4'b0010, exp_rr), TMO + 1, 0, 1'b1);

    // Backpressure for 20 cycles, with requests pending and codes changing.
    do_round(4'b0001, 24'h00_00_11, pick(4'b0001, exp_rr), 6, 20, 1'b1);

    // Reset during WAIT.
    key_complete = 1'b1;
    rise_delay   = -1;
    rsp_ready    = 1'b1;
    req_sv_num   = 24'h00_21_00 << 6;
    req_valid    = 4'b0100;
    #1;
    check("mid_grant", req_ready, 4'b0100);
    step();
    step();
    step();
    req_valid = 4'hF;
    check("mid_busy", busy, 1'b1);
    sync_rst_in = 1'b1;
    #1;
    check_zero("mid_reset");
    step();
    sync_rst_in = 1'b0;
    req_valid   = '0;
    exp_rr      = 0;
    viol = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("no_dropped_rsp", viol, 0);
    do_round(4'hF, 24'h0C_0B_0A, 0, 5, 0, 1'b1);

    // Randomized rounds against the pointer model.
    for (int r = 0; r < 40; r++) begin
      rv  = 4'($urandom_range(1, 15));
      svs = 24'($urandom);
      d   = int'($urandom_range(0, 20));
      if (d == 20) d = -1;
      do_round(rv, svs, pick(rv, exp_rr), d, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
